rtype_exec_ctrl: RTL and testbench

Multi-cycle R-type execute controller that sits directly upstream of the 32-bit arithmetic unit (au).
- Holds the 32x32 register file.
- Accepts one R-type instruction at a time over a valid/ready handshake and reads rs/rt.
- Decodes funct into the au 3-bit select, registers the au operands, and writes au_out back to rd.
- Latches au_cout into a carry flag.
- The au itself stays combinational and external; this block drives its A/B/select and consumes out/cout.

---
 rtl/rtype_exec_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rtype_exec_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rtype_exec_ctrl : multi-cycle R-type execute controller for an external au |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rtype_exec_ctrl #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic            ld_en_i,
  input  logic [4:0]      ld_addr_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic [XLEN-1:0] au_a_o,
  output logic [XLEN-1:0] au_b_o,
  output logic [2:0]      au_sel_o,
  input  logic [XLEN-1:0] au_out_i,
  input  logic            au_cout_i,
  output logic            done_o,
  output logic            illegal_o,
  output logic            carry_flag_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  localparam logic [5:0] c_funct_add = 6'h20;
  localparam logic [5:0] c_funct_sub = 6'h22;
  localparam logic [5:0] c_funct_inc = 6'h28;
  localparam logic [5:0] c_funct_dec = 6'h29;

  state_t          state_q;
  logic [5:0]      opcode_q;
  logic [5:0]      funct_q;
  logic [4:0]      rs_q;
  logic [4:0]      rt_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] au_a_q;
  logic [XLEN-1:0] au_b_q;
  logic [2:0]      au_sel_q;
  logic [XLEN-1:0] result_q;
  logic            cout_q;
  logic            pend_ill_q;
  logic            done_q;
  logic            illegal_q;
  logic            carry_q;

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            dec_legal;
  logic [2:0]      dec_sel;
  logic            unused_shamt;

  // shamt has no meaning for the supported functs
  assign unused_shamt = ^instr_i[10:6];

  assign rs_val = (rs_q == 5'd0) ? '0 : regs_q[rs_q];
  assign rt_val = (rt_q == 5'd0) ? '0 : regs_q[rt_q];

  always_comb begin
    dec_legal = 1'b0;
    dec_sel   = 3'b000;
    if (opcode_q == 6'd0) begin
      case (funct_q)
        c_funct_add: begin dec_legal = 1'b1; dec_sel = 3'b000; end
        c_funct_sub: begin dec_legal = 1'b1; dec_sel = 3'b100; end
        c_funct_inc: begin dec_legal = 1'b1; dec_sel = 3'b010; end
        c_funct_dec: begin dec_legal = 1'b1; dec_sel = 3'b110; end
        default:     begin dec_legal = 1'b0; dec_sel = 3'b000; end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      funct_q    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      au_a_q     <= '0;
      au_b_q     <= '0;
      au_sel_q   <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      pend_ill_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      carry_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A same-cycle load lands before DECODE reads the operands
          if (ld_en_i && (ld_addr_i != 5'd0)) begin
            regs_q[ld_addr_i] <= ld_data_i;
          end
          if (instr_valid_i) begin
            opcode_q <= instr_i[31:26];
            rs_q     <= instr_i[25:21];
            rt_q     <= instr_i[20:16];
            rd_q     <= instr_i[15:11];
            funct_q  <= instr_i[5:0];
            state_q  <= S_DECODE;
          end
        end
        S_DECODE: begin
          au_a_q     <= rs_val;
          au_b_q     <= rt_val;
          au_sel_q   <= dec_sel;
          pend_ill_q <= ~dec_legal;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= au_out_i;
          cout_q   <= au_cout_i;
          state_q  <= S_WB;
        end
        S_WB: begin
          if (!pend_ill_q) begin
            if (rd_q != 5'd0) begin
              regs_q[rd_q] <= result_q;
            end
            carry_q <= cout_q;
          end
          done_q    <= 1'b1;
          illegal_q <= pend_ill_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready_o = (state_q == S_IDLE);
  assign au_a_o        = au_a_q;
  assign au_b_o        = au_b_q;
  assign au_sel_o      = au_sel_q;
  assign done_o        = done_q;
  assign illegal_o     = illegal_q;
  assign carry_flag_o  = carry_q;
  assign dbg_data_o    = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_rtype_exec_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rtype_exec_ctrl : directed vector bench for rtype_exec_ctrl            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rtype_exec_ctrl;

  logic        clk;
  logic        reset_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic        ld_en_i;
  logic [4:0]  ld_addr_i;
  logic [31:0] ld_data_i;
  logic [31:0] au_a_o;
  logic [31:0] au_b_o;
  logic [2:0]  au_sel_o;
  logic [31:0] au_out_i;
  logic        au_cout_i;
  logic        done_o;
  logic        illegal_o;
  logic        carry_flag_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;

  int checks = 0;
  int errors = 0;

  rtype_exec_ctrl #(.NREG(32), .XLEN(32)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .ld_en_i       (ld_en_i),
    .ld_addr_i     (ld_addr_i),
    .ld_data_i     (ld_data_i),
    .au_a_o        (au_a_o),
    .au_b_o        (au_b_o),
    .au_sel_o      (au_sel_o),
    .au_out_i      (au_out_i),
    .au_cout_i     (au_cout_i),
    .done_o        (done_o),
    .illegal_o     (illegal_o),
    .carry_flag_o  (carry_flag_o),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_data_o    (dbg_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural arithmetic unit sitting downstream of the controller
  logic [32:0] au_sum;
  always_comb begin
    case (au_sel_o)
      3'b000:  au_sum = {1'b0, au_a_o} + {1'b0, au_b_o};
      3'b100:  au_sum = {1'b0, au_a_o} + {1'b0, ~au_b_o} + 33'd1;
      3'b010:  au_sum = {1'b0, au_a_o} + 33'd1;
      3'b110:  au_sum = {1'b0, au_a_o} + {1'b0, 32'hFFFF_FFFF};
      default: au_sum = '0;
    endcase
  end
  assign au_out_i  = au_sum[31:0];
  assign au_cout_i = au_sum[32];

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] val;
    logic        c;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] funct);
    return {op, rs, rt, rd, 5'd3, funct};
  endfunction

  // Called at a negedge while idle; returns one negedge later
  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en_i   = 1'b1;
    ld_addr_i = a;
    ld_data_i = d;
    @(negedge clk);
    ld_en_i   = 1'b0;
  endtask

  task automatic rd_dbg(input logic [4:0] a, output logic [31:0] d);
    dbg_addr_i = a;
    #1;
    d = dbg_data_o;
  endtask

  // Issues one instruction; returns at the negedge where done is seen
  task automatic run_instr(input logic [31:0] ins, output int lat, output logic [2:0] sel_exec,
                           output logic ill_seen, output logic busy_ready);
    lat        = -1;
    sel_exec   = 3'bxxx;
    ill_seen   = 1'bx;
    busy_ready = 1'b0;
    instr_valid_i = 1'b1;
    instr_i       = ins;
    @(negedge clk);
    instr_valid_i = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2) sel_exec = au_sel_o;
      if (done_o) begin
        lat      = n;
        ill_seen = illegal_o;
        break;
      end
      if (instr_ready_o) busy_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    logic [2:0]  sel;
    logic        ill;
    logic        busy;
    logic [7:0]  rdy_seen;
    logic [7:0]  done_seen;

    //                 op     rs     rt     rd     funct  sel     ill   val            c
    vecs[0] = '{6'h00, 5'd1,  5'd2,  5'd3,  6'h20, 3'b000, 1'b0, 32'd12,       1'b0};
    vecs[1] = '{6'h00, 5'd11, 5'd12, 5'd4,  6'h22, 3'b100, 1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{6'h00, 5'd12, 5'd11, 5'd5,  6'h22, 3'b100, 1'b0, 32'd2,        1'b1};
    vecs[3] = '{6'h08, 5'd1,  5'd2,  5'd4,  6'h20, 3'b000, 1'b1, 32'hFFFFFFFE, 1'b1};
    vecs[4] = '{6'h00, 5'd1,  5'd2,  5'd5,  6'h24, 3'b000, 1'b1, 32'd2,        1'b1};
    vecs[5] = '{6'h00, 5'd6,  5'd0,  5'd7,  6'h28, 3'b010, 1'b0, 32'd0,        1'b1};
    vecs[6] = '{6'h00, 5'd0,  5'd0,  5'd8,  6'h29, 3'b110, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{6'h00, 5'd1,  5'd2,  5'd0,  6'h20, 3'b000, 1'b0, 32'd0,        1'b0};
    vecs[8] = '{6'h00, 5'd0,  5'd1,  5'd9,  6'h20, 3'b000, 1'b0, 32'd5,        1'b0};

    reset_i       = 1'b1;
    instr_valid_i = 1'b0;
    instr_i       = '0;
    ld_en_i       = 1'b0;
    ld_addr_i     = '0;
    ld_data_i     = '0;
    dbg_addr_i    = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_o}, 32'd0);
    chk("reset_carry", {31'd0, carry_flag_o}, 32'd0);
    chk("reset_au_a", au_a_o, 32'd0);
    chk("reset_au_sel", {29'd0, au_sel_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    load(5'd1, 32'd5);
    load(5'd2, 32'd7);
    load(5'd6, 32'hFFFF_FFFF);
    load(5'd11, 32'd3);
    load(5'd12, 32'd5);
    load(5'd0, 32'h1234);
    rd_dbg(5'd1, d);  chk("preload_r1", d, 32'd5);
    rd_dbg(5'd0, d);  chk("preload_r0", d, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_instr(enc(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct),
                lat, sel, ill, busy);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      chk($sformatf("v%0d_sel_exec", i), {29'd0, sel}, {29'd0, vecs[i].sel});
      chk($sformatf("v%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].ill});
      chk($sformatf("v%0d_ready_busy", i), {31'd0, busy}, 32'd0);
      rd_dbg(vecs[i].rd, d);
      chk($sformatf("v%0d_rd_value", i), d, vecs[i].val);
      chk($sformatf("v%0d_carry", i), {31'd0, carry_flag_o}, {31'd0, vecs[i].c});
    end

    // Back-to-back with instr_valid held: second (dependent) accepted at done
    @(negedge clk);
    rdy_seen  = '0;
    done_seen = '0;
    instr_valid_i = 1'b1;
    instr_i       = enc(6'h00, 5'd1, 5'd2, 5'd13, 6'h20);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      rdy_seen[n-1]  = instr_ready_o;
      done_seen[n-1] = done_o;
      if (n == 4) instr_i = enc(6'h00, 5'd13, 5'd1, 5'd14, 6'h20);
      if (n == 8) instr_valid_i = 1'b0;
    end
    chk("b2b_ready_pattern", {24'd0, rdy_seen}, 32'h0000_0088);
    chk("b2b_done_pattern", {24'd0, done_seen}, 32'h0000_0088);
    rd_dbg(5'd13, d); chk("b2b_r13", d, 32'd12);
    rd_dbg(5'd14, d); chk("b2b_r14", d, 32'd17);

    // ld_en during EXEC is ignored
    @(negedge clk);
    instr_valid_i = 1'b1;
    instr_i       = enc(6'h00, 5'd1, 5'd2, 5'd15, 6'h20);
    @(negedge clk);
    instr_valid_i = 1'b0;
    @(negedge clk);
    ld_en_i   = 1'b1;
    ld_addr_i = 5'd1;
    ld_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_en_i = 1'b0;
    @(negedge clk);
    chk("ldexec_done", {31'd0, done_o}, 32'd1);
    rd_dbg(5'd1, d);  chk("ldexec_r1_kept", d, 32'd5);
    rd_dbg(5'd15, d); chk("ldexec_r15", d, 32'd12);

    // Reset asserted during EXEC aborts the instruction
    @(negedge clk);
    instr_valid_i = 1'b1;
    instr_i       = enc(6'h00, 5'd1, 5'd2, 5'd16, 6'h20);
    @(negedge clk);
    instr_valid_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("rst_async_ready", {31'd0, instr_ready_o}, 32'd1);
    chk("rst_async_au_a", au_a_o, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, instr_ready_o}, 32'd1);
    done_seen = '0;
    for (int n = 0; n < 6; n++) begin
      if (done_o) done_seen[0] = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_done", {31'd0, done_seen[0]}, 32'd0);
    rd_dbg(5'd16, d); chk("rst_r16", d, 32'd0);
    rd_dbg(5'd1, d);  chk("rst_r1_cleared", d, 32'd0);
    chk("rst_carry", {31'd0, carry_flag_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
